// File: rtl/cnt_cmd_arbiter.sv
// Round-robin arbiter for two counter-command requesters; replays the granted
// command as a stream of 3-bit counter state codes plus a registered load value.
module cnt_cmd_arbiter #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req,
   input  logic [1:0]        cmd0,
   input  logic [1:0]        cmd1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   output logic [1:0]        gnt,
   output logic              done,
   output logic              busy,
   output logic [2:0]        state,
   output logic [DATA_W-1:0] d_load
);

   typedef enum logic {
      ARB_IDLE,
      ARB_RUN
   } arbState_t;

   localparam logic [1:0] CMD_CLR  = 2'b00;
   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_INC  = 2'b10;
   localparam logic [1:0] CMD_DEC  = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_LOAD = 3'b001;
   localparam logic [2:0] ST_INC  = 3'b010;
   localparam logic [2:0] ST_INC2 = 3'b011;
   localparam logic [2:0] ST_DEC  = 3'b100;
   localparam logic [2:0] ST_DEC2 = 3'b101;

   arbState_t         fsm_q, fsm_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              done_q, done_d;
   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] dLoad_q, dLoad_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic              last_q, last_d;

   logic              sel;
   logic [1:0]        selCmd;
   logic [DATA_W-1:0] selData;
   logic [LEN_W-1:0]  selLen;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q    <= ARB_IDLE;
         gnt_q    <= 2'b00;
         done_q   <= 1'b0;
         state_q  <= ST_IDLE;
         dLoad_q  <= '0;
         cmd_q    <= CMD_CLR;
         data_q   <= '0;
         remain_q <= '0;
         last_q   <= 1'b1;
      end else begin
         fsm_q    <= fsm_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         state_q  <= state_d;
         dLoad_q  <= dLoad_d;
         cmd_q    <= cmd_d;
         data_q   <= data_d;
         remain_q <= remain_d;
         last_q   <= last_d;
      end
   end

   // With both requesting, the one not granted last wins; last_q resets to 1 so requester 0 goes first.
   always_comb begin
      if (req == 2'b11) begin
         sel = ~last_q;
      end else begin
         sel = req[1];
      end
      selCmd  = sel ? cmd1  : cmd0;
      selData = sel ? data1 : data0;
      selLen  = sel ? len1  : len0;
   end

   always_comb begin
      fsm_d    = fsm_q;
      gnt_d    = 2'b00;
      done_d   = 1'b0;
      state_d  = state_q;
      dLoad_d  = dLoad_q;
      cmd_d    = cmd_q;
      data_d   = data_q;
      remain_d = remain_q;
      last_d   = last_q;
      unique case (fsm_q)
         ARB_IDLE: begin
            if (|req) begin
               gnt_d  = sel ? 2'b10 : 2'b01;
               last_d = sel;
               cmd_d  = selCmd;
               data_d = selData;
               fsm_d  = ARB_RUN;
               // A LOAD onto a LOAD code needs an IDLE bubble so the counter sees a code change.
               unique case (selCmd)
                  CMD_CLR:  remain_d = LEN_W'(1);
                  CMD_LOAD: remain_d = (state_q == ST_LOAD) ? LEN_W'(2) : LEN_W'(1);
                  default:  remain_d = (selLen == '0) ? LEN_W'(1) : selLen;
               endcase
            end
         end
         ARB_RUN: begin
            unique case (cmd_q)
               CMD_CLR: state_d = ST_IDLE;
               CMD_LOAD: begin
                  if (remain_q == LEN_W'(2)) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_LOAD;
                     dLoad_d = data_q;
                  end
               end
               CMD_INC: state_d = (state_q == ST_INC) ? ST_INC2 : ST_INC;
               CMD_DEC: state_d = (state_q == ST_DEC) ? ST_DEC2 : ST_DEC;
            endcase
            remain_d = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
               done_d = 1'b1;
               fsm_d  = ARB_IDLE;
            end
         end
      endcase
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign busy   = (fsm_q == ARB_RUN);
   assign state  = state_q;
   assign d_load = dLoad_q;

endmodule

// File: tb/tb_cnt_cmd_arbiter.sv
// Scoreboard bench for cnt_cmd_arbiter: a reference model queues the per-cycle
// outputs expected for each command and every test drains and compares them.
module tb_cnt_cmd_arbiter;

   localparam logic [1:0] CMD_CLR  = 2'b00;
   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_INC  = 2'b10;
   localparam logic [1:0] CMD_DEC  = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_LOAD = 3'b001;
   localparam logic [2:0] ST_INC  = 3'b010;
   localparam logic [2:0] ST_INC2 = 3'b011;
   localparam logic [2:0] ST_DEC  = 3'b100;
   localparam logic [2:0] ST_DEC2 = 3'b101;

   typedef struct packed {
      logic [1:0] gnt;
      logic       done;
      logic       busy;
      logic [2:0] state;
      logic [7:0] dload;
   } obs_t;

   logic       clk;
   logic       reset_n;
   logic [1:0] req;
   logic [1:0] cmd0, cmd1;
   logic [7:0] data0, data1;
   logic [3:0] len0, len1;
   logic [1:0] gnt;
   logic       done;
   logic       busy;
   logic [2:0] state;
   logic [7:0] d_load;

   obs_t expQ[$];
   int   vectors;
   int   miscompares;
   logic [2:0] mState;
   logic [7:0] mLoad;

   cnt_cmd_arbiter #(.DATA_W(8), .LEN_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .req(req),
      .cmd0(cmd0), .cmd1(cmd1), .data0(data0), .data1(data1),
      .len0(len0), .len1(len1),
      .gnt(gnt), .done(done), .busy(busy), .state(state), .d_load(d_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string fmt(input obs_t o);
      return $sformatf("gnt=%b done=%b busy=%b state=%b d_load=%h",
                       o.gnt, o.done, o.busy, o.state, o.dload);
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.gnt = gnt; o.done = done; o.busy = busy; o.state = state; o.dload = d_load;
      return o;
   endfunction

   // Reference model: one grant cycle, then one entry per step with done on the last.
   task automatic pushExpected(input int who, input logic [1:0] c,
                               input logic [7:0] d, input logic [3:0] l);
      logic [2:0] steps[$];
      logic [2:0] cur;
      obs_t       e;
      int         n;
      e.gnt = (who == 0) ? 2'b01 : 2'b10;
      e.done = 1'b0; e.busy = 1'b1; e.state = mState; e.dload = mLoad;
      expQ.push_back(e);
      cur = mState;
      case (c)
         CMD_CLR: steps.push_back(ST_IDLE);
         CMD_LOAD: begin
            if (cur == ST_LOAD) steps.push_back(ST_IDLE);
            steps.push_back(ST_LOAD);
         end
         default: begin
            n = (l == 4'd0) ? 1 : int'(l);
            for (int i = 0; i < n; i++) begin
               if (c == CMD_INC) cur = (cur == ST_INC) ? ST_INC2 : ST_INC;
               else              cur = (cur == ST_DEC) ? ST_DEC2 : ST_DEC;
               steps.push_back(cur);
            end
         end
      endcase
      for (int i = 0; i < steps.size(); i++) begin
         if (c == CMD_LOAD && i == steps.size() - 1) mLoad = d;
         mState  = steps[i];
         e.gnt   = 2'b00;
         e.state = steps[i];
         e.dload = mLoad;
         e.done  = (i == steps.size() - 1);
         e.busy  = !e.done;
         expQ.push_back(e);
      end
   endtask

   task automatic applyStimulus(input int who, input logic [1:0] c,
                                input logic [7:0] d, input logic [3:0] l);
      if (who == 0) begin cmd0 = c; data0 = d; len0 = l; end
      else          begin cmd1 = c; data1 = d; len1 = l; end
      req[who] = 1'b1;
      pushExpected(who, c, d, l);
   endtask

   task automatic sampleCycle(output obs_t o);
      @(posedge clk);
      @(negedge clk);
      o = observe();
   endtask

   task automatic test_reset();
      obs_t o, e, rst;
      rst = '0;
      reset_n = 1'b0;
      req = 2'b00;
      repeat (3) @(negedge clk);
      o = observe();
      vectors++;
      if (o !== rst) begin
         miscompares++;
         $display("[TB] FAIL reset_init: observed %s required %s", fmt(o), fmt(rst));
      end
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, CMD_INC, 8'h00, 4'd5);
      for (int i = 0; i < 3; i++) begin
         sampleCycle(o);
         e = expQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL reset_prerun[%0d]: observed %s required %s", i, fmt(o), fmt(e));
         end
         if (i == 0) req = 2'b00;
      end
      #2 reset_n = 1'b0;
      #1 o = observe();
      vectors++;
      if (o !== rst) begin
         miscompares++;
         $display("[TB] FAIL reset_async: observed %s required %s", fmt(o), fmt(rst));
      end
      expQ.delete();
      mState = ST_IDLE;
      mLoad  = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fairness();
      obs_t o, e;
      int   w;
      cmd0 = CMD_INC; len0 = 4'd1; data0 = 8'h00;
      cmd1 = CMD_DEC; len1 = 4'd1; data1 = 8'h00;
      req = 2'b11;
      for (int r = 0; r < 4; r++) begin
         w = r % 2;
         pushExpected(w, (w == 0) ? CMD_INC : CMD_DEC, 8'h00, 4'd1);
         for (int i = 0; expQ.size() > 0; i++) begin
            sampleCycle(o);
            e = expQ.pop_front();
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("[TB] FAIL fairness r%0d[%0d]: observed %s required %s", r, i, fmt(o), fmt(e));
            end
            if (i == 0) req[w] = 1'b0;
         end
         if (r < 3) req[w] = 1'b1;
         else       req = 2'b00;
      end
   endtask

   task automatic test_single(input string name, input int who, input logic [1:0] c,
                              input logic [7:0] d, input logic [3:0] l);
      obs_t o, e;
      applyStimulus(who, c, d, l);
      for (int i = 0; expQ.size() > 0; i++) begin
         sampleCycle(o);
         e = expQ.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: observed %s required %s", name, i, fmt(o), fmt(e));
         end
         if (i == 0) req = 2'b00;
      end
   endtask

   task automatic test_idle_hold();
      obs_t o, e;
      e.gnt = 2'b00; e.done = 1'b0; e.busy = 1'b0; e.state = mState; e.dload = mLoad;
      for (int i = 0; i < 3; i++) begin
         sampleCycle(o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL idle_hold[%0d]: observed %s required %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      mState = ST_IDLE; mLoad = 8'h00;
      req = 2'b00;
      cmd0 = CMD_CLR; cmd1 = CMD_CLR;
      data0 = 8'h00; data1 = 8'h00;
      len0 = 4'd0; len1 = 4'd0;
      reset_n = 1'b0;
      test_reset();
      test_fairness();
      test_single("clr_to_idle", 0, CMD_CLR, 8'h00, 4'd0);
      test_single("inc_len3", 0, CMD_INC, 8'h00, 4'd3);
      test_single("load_a5", 1, CMD_LOAD, 8'hA5, 4'd7);
      test_single("load_3c", 1, CMD_LOAD, 8'h3C, 4'd0);
      test_single("clr_after_load", 0, CMD_CLR, 8'h00, 4'd0);
      test_single("dec_len0", 0, CMD_DEC, 8'h00, 4'd0);
      test_single("dec_len15", 1, CMD_DEC, 8'h00, 4'd15);
      test_single("clr_a", 1, CMD_CLR, 8'h00, 4'd0);
      test_single("clr_noop", 0, CMD_CLR, 8'h00, 4'd0);
      test_single("load_back_to_back", 0, CMD_LOAD, 8'h5A, 4'd0);
      test_idle_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
